// File: rtl/approx_adder_error_monitor_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2
  } state_e;

  localparam int DEF_N     = 16;
  localparam int DEF_CNT_W = 24;

  // Width that holds (2^CNT_W - 1) samples of an (N+1)-bit distance without overflow.
  function automatic int sum_width(input int n, input int cnt_w);
    return n + 1 + cnt_w;
  endfunction

endpackage

// File: rtl/approx_adder_error_monitor_seq_divider.sv
// Restoring divider: loads on start, then produces one quotient bit per cycle.
// done pulses in the cycle after the final iteration; outputs stay stable until the next start.
module seq_divider #(
  parameter int DVD_W = 41,
  parameter int DVS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   shifted, trial;

  // Load operands on start, otherwise shift-subtract one bit while iterations remain.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[DVD_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CW'(DVD_W);
    end else if (cnt_q != '0) begin
      // trial MSB set means shifted < divisor: keep the partial remainder
      if (!trial[DVS_W]) begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Streaming error monitor for an approximate adder: accumulates error count,
// zero-reference count, summed and maximum error distance, then derives MED
// (quotient/remainder) with a sequential divider.
module approx_adder_error_monitor
  import approx_err_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = sum_width(N, CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       exact_sum,
  input  logic [N:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] zero_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [N:0]       max_ed,
  output logic [SUM_W-1:0] med_q,
  output logic [CNT_W-1:0] med_r
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, target_q, target_d;
  logic [CNT_W-1:0] err_q, err_d, zero_q, zero_d, medr_q, medr_d;
  logic [SUM_W-1:0] sum_q, sum_d, medq_q, medq_d;
  logic [N:0]       max_q, max_d, ed;
  logic             done_q, done_d, rv_q, rv_d, zpend_q, zpend_d;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_quo;
  logic [CNT_W-1:0] div_rem;

  assign ed = (approx_sum >= exact_sum) ? (approx_sum - exact_sum) : (exact_sum - approx_sum);

  // Divider is kicked on the final accept with the already-updated sum, so it
  // runs in parallel with the first DIVIDE cycle.
  seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (sum_d),
    .divisor   (target_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // FSM next state, accumulator updates and result loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    err_d     = err_q;
    zero_d    = zero_q;
    sum_d     = sum_q;
    max_d     = max_q;
    medq_d    = medq_q;
    medr_d    = medr_q;
    zpend_d   = 1'b0;
    // an empty campaign finishes one cycle after its start
    done_d    = zpend_q;
    rv_d      = rv_q | zpend_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = '0;
          zero_d = '0;
          sum_d  = '0;
          max_d  = '0;
          medq_d = '0;
          medr_d = '0;
          cnt_d  = '0;
          rv_d   = 1'b0;
          if (num_samples != '0) begin
            target_d = num_samples;
            state_d  = ACCUM;
          end else begin
            zpend_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          sum_d  = sum_q + SUM_W'(ed);
          err_d  = err_q + CNT_W'(ed != '0);
          zero_d = zero_q + CNT_W'(exact_sum == '0);
          max_d  = (ed > max_q) ? ed : max_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == target_q) begin
            state_d   = DIVIDE;
            div_start = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (div_done && !div_busy) begin
          medq_d  = div_quo;
          medr_d  = div_rem;
          done_d  = 1'b1;
          rv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Monitor state registers; reset discards any partial campaign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      err_q    <= '0;
      zero_q   <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      medq_q   <= '0;
      medr_q   <= '0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      zpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      medq_q   <= medq_d;
      medr_q   <= medr_d;
      done_q   <= done_d;
      rv_q     <= rv_d;
      zpend_q  <= zpend_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result_valid = rv_q;
  assign err_count    = err_q;
  assign zero_count   = zero_q;
  assign sum_ed       = sum_q;
  assign max_ed       = max_q;
  assign med_q        = medq_q;
  assign med_r        = medr_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Randomised and directed bench for the approximate-adder error monitor.
module tb_approx_adder_error_monitor;

  localparam int N     = 16;
  localparam int CNT_W = 24;
  localparam int SUM_W = N + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N:0]       exact_sum = '0;
  logic [N:0]       approx_sum = '0;
  logic             busy, done, result_valid;
  logic [CNT_W-1:0] err_count, zero_count, med_r;
  logic [SUM_W-1:0] sum_ed, med_q;
  logic [N:0]       max_ed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [N:0]  ex_a [64];
  logic [N:0]  ap_a [64];
  logic [63:0] e_err, e_zero, e_sum, e_max, e_q, e_r;

  approx_adder_error_monitor #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exact_sum    (exact_sum),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .err_count    (err_count),
    .zero_count   (zero_count),
    .sum_ed       (sum_ed),
    .max_ed       (max_ed),
    .med_q        (med_q),
    .med_r        (med_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: metrics straight from the definitions over the stored pairs.
  task automatic model(input int n);
    logic [63:0] a, e, d;
    e_err = 0; e_zero = 0; e_sum = 0; e_max = 0;
    for (int i = 0; i < n; i++) begin
      a = 64'(ap_a[i]);
      e = 64'(ex_a[i]);
      d = (a > e) ? a - e : e - a;
      e_sum = e_sum + d;
      if (d != 0) e_err = e_err + 1;
      if (e == 0) e_zero = e_zero + 1;
      if (d > e_max) e_max = d;
    end
    e_q = e_sum / 64'(n);
    e_r = e_sum % 64'(n);
  endtask

  // Drives one campaign; stray samples (and optionally a start) are presented during DIVIDE.
  task automatic run_campaign(input int n, input bit gaps, input bit poke_div,
                              output int k_last, output int done_at,
                              output logic done_after, output logic busy_at_done);
    int idx = 0;
    int guard = 0;
    bit will;
    k_last = -1; done_at = -1; done_after = 1'bx; busy_at_done = 1'bx;
    start = 1'b1; num_samples = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < n && guard < 400) begin
      in_valid = !(gaps && guard[0]);
      if (in_valid) begin
        exact_sum = ex_a[idx]; approx_sum = ap_a[idx];
      end else begin
        exact_sum = 17'($urandom); approx_sum = 17'($urandom);
      end
      will = in_valid && in_ready;
      @(posedge clk); #1;
      if (will) begin idx++; k_last = cyc; end
      guard++;
    end
    guard = 0;
    while (done_at < 0 && guard < 200) begin
      in_valid = 1'b1; exact_sum = 17'($urandom); approx_sum = 17'($urandom);
      start = poke_div && (guard == 5);
      num_samples = 24'd7;
      @(posedge clk); #1;
      if (done === 1'b1) begin done_at = cyc; busy_at_done = busy; end
      guard++;
    end
    in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, done, result_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, in_ready, done, result_valid});
    end
    checks++;
    if ((err_count | zero_count | med_r) !== '0 || (sum_ed | med_q) !== '0 || max_ed !== '0) begin
      errors++; $display("FAIL reset_results: got err=%0h zero=%0h sum=%0h max=%0h q=%0h r=%0h want all 0",
                         err_count, zero_count, sum_ed, max_ed, med_q, med_r);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic test_directed;
    int n, k, d;
    logic da, bd;
    for (int id = 0; id < 3; id++) begin
      case (id)
        0: begin n = 4; for (int i = 0; i < 4; i++) begin ex_a[i] = 17'h1234; ap_a[i] = 17'h1234; end end
        1: begin
          n = 3;
          ex_a[0] = 17'd100; ap_a[0] = 17'd90;
          ex_a[1] = 17'd50;  ap_a[1] = 17'd53;
          ex_a[2] = 17'd0;   ap_a[2] = 17'd0;
        end
        default: begin n = 1; ex_a[0] = 17'h10000; ap_a[0] = 17'h0FFFF; end
      endcase
      model(n);
      run_campaign(n, 1'b0, 1'b0, k, d, da, bd);
      checks++;
      if (d - k !== SUM_W + 1) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", id, d - k, SUM_W + 1); end
      checks++;
      if (bd !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: busy@done=%b done_next=%b want 0 0", id, bd, da); end
      checks++;
      if (err_count !== e_err[CNT_W-1:0] || zero_count !== e_zero[CNT_W-1:0]) begin
        errors++; $display("FAIL dir%0d_counts: got err=%0d zero=%0d want err=%0d zero=%0d", id, err_count, zero_count, e_err, e_zero);
      end
      checks++;
      if (sum_ed !== e_sum[SUM_W-1:0] || max_ed !== e_max[N:0]) begin
        errors++; $display("FAIL dir%0d_ed: got sum=%0d max=%0d want sum=%0d max=%0d", id, sum_ed, max_ed, e_sum, e_max);
      end
      checks++;
      if (med_q !== e_q[SUM_W-1:0] || med_r !== e_r[CNT_W-1:0] || result_valid !== 1'b1) begin
        errors++; $display("FAIL dir%0d_med: got q=%0d r=%0d rv=%b want q=%0d r=%0d rv=1", id, med_q, med_r, result_valid, e_q, e_r);
      end
      if (id == 1) begin
        checks++;
        if (med_q !== 41'd4 || med_r !== 24'd1 || sum_ed !== 41'd13 || max_ed !== 17'd10) begin
          errors++; $display("FAIL dir1_const: got q=%0d r=%0d sum=%0d max=%0d want 4 1 13 10", med_q, med_r, sum_ed, max_ed);
        end
      end
    end
  endtask

  task automatic test_zero_samples;
    bit busy_seen = 1'b0;
    start = 1'b1; num_samples = '0;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen |= (busy !== 1'b0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: done=%b want 0", done); end
    @(posedge clk); #1;
    busy_seen |= (busy !== 1'b0);
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b1) begin
      errors++; $display("FAIL zero_done: got done=%b rv=%b want 1 1", done, result_valid);
    end
    checks++;
    if ((err_count | zero_count | med_r) !== '0 || (sum_ed | med_q) !== '0 || max_ed !== '0) begin
      errors++; $display("FAIL zero_results: got err=%0h sum=%0h max=%0h q=%0h want all 0", err_count, sum_ed, max_ed, med_q);
    end
    @(posedge clk); #1;
    busy_seen |= (busy !== 1'b0);
    checks++;
    if (done !== 1'b0 || busy_seen) begin errors++; $display("FAIL zero_pulse: done=%b busy_seen=%b want 0 0", done, busy_seen); end
  endtask

  task automatic test_gaps;
    int k, d;
    logic da, bd;
    logic [SUM_W-1:0] g_sum, g_q;
    logic [CNT_W-1:0] g_err, g_r;
    for (int i = 0; i < 5; i++) begin
      ex_a[i] = 17'($urandom);
      ap_a[i] = ex_a[i] + 17'($urandom_range(0, 40)) - 17'd20;
    end
    model(5);
    run_campaign(5, 1'b1, 1'b0, k, d, da, bd);
    g_sum = sum_ed; g_q = med_q; g_err = err_count; g_r = med_r;
    checks++;
    if (g_sum !== e_sum[SUM_W-1:0] || g_err !== e_err[CNT_W-1:0] || max_ed !== e_max[N:0]) begin
      errors++; $display("FAIL gaps_accum: got sum=%0d err=%0d max=%0d want %0d %0d %0d", g_sum, g_err, max_ed, e_sum, e_err, e_max);
    end
    checks++;
    if (d - k !== SUM_W + 1) begin errors++; $display("FAIL gaps_latency: got %0d want %0d", d - k, SUM_W + 1); end
    run_campaign(5, 1'b0, 1'b0, k, d, da, bd);
    checks++;
    if (sum_ed !== g_sum || med_q !== g_q || err_count !== g_err || med_r !== g_r || med_q !== e_q[SUM_W-1:0]) begin
      errors++; $display("FAIL gaps_vs_b2b: got sum=%0d q=%0d want sum=%0d q=%0d", sum_ed, med_q, g_sum, e_q);
    end
  endtask

  task automatic test_reset_rerun;
    int k, d;
    logic da, bd;
    start = 1'b1; num_samples = 24'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; exact_sum = 17'd1000; approx_sum = 17'd1500;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (sum_ed !== 41'd1000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL partial_accum: got sum=%0d ready=%b want 1000 1", sum_ed, in_ready);
    end
    rst = 1'b1; #1;
    checks++;
    if ({busy, in_ready, done, result_valid} !== 4'b0 || sum_ed !== '0 || err_count !== '0 || max_ed !== '0) begin
      errors++; $display("FAIL midreset: got ctrl=%b sum=%0d err=%0d max=%0d want 0", {busy, in_ready, done, result_valid}, sum_ed, err_count, max_ed);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ex_a[i] = 17'($urandom_range(0, 3));
      ap_a[i] = 17'($urandom_range(0, 300));
    end
    model(4);
    run_campaign(4, 1'b0, 1'b1, k, d, da, bd);
    checks++;
    if (sum_ed !== e_sum[SUM_W-1:0] || zero_count !== e_zero[CNT_W-1:0] || err_count !== e_err[CNT_W-1:0]) begin
      errors++; $display("FAIL rerun_accum: got sum=%0d zero=%0d err=%0d want %0d %0d %0d", sum_ed, zero_count, err_count, e_sum, e_zero, e_err);
    end
    checks++;
    if (med_q !== e_q[SUM_W-1:0] || med_r !== e_r[CNT_W-1:0] || d - k !== SUM_W + 1) begin
      errors++; $display("FAIL rerun_med: got q=%0d r=%0d lat=%0d want %0d %0d %0d", med_q, med_r, d - k, e_q, e_r, SUM_W + 1);
    end
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b1) begin
      errors++; $display("FAIL start_in_divide: got busy=%b rv=%b want 0 1", busy, result_valid);
    end
  endtask

  task automatic test_random;
    int n, k, d;
    logic da, bd;
    for (int c = 0; c < 8; c++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: begin ex_a[i] = 17'($urandom); ap_a[i] = ex_a[i]; end
          1: begin ex_a[i] = 17'($urandom); ap_a[i] = 17'($urandom); end
          2: begin ex_a[i] = '0; ap_a[i] = 17'($urandom_range(0, 5)); end
          default: begin ex_a[i] = 17'($urandom); ap_a[i] = ex_a[i] ^ 17'(1 << $urandom_range(0, 16)); end
        endcase
      end
      model(n);
      run_campaign(n, c[0], 1'b0, k, d, da, bd);
      checks++;
      if (err_count !== e_err[CNT_W-1:0] || zero_count !== e_zero[CNT_W-1:0] || max_ed !== e_max[N:0]) begin
        errors++; $display("FAIL rand%0d_counts: got err=%0d zero=%0d max=%0d want %0d %0d %0d", c, err_count, zero_count, max_ed, e_err, e_zero, e_max);
      end
      checks++;
      if (sum_ed !== e_sum[SUM_W-1:0] || med_q !== e_q[SUM_W-1:0] || med_r !== e_r[CNT_W-1:0]) begin
        errors++; $display("FAIL rand%0d_med: got sum=%0d q=%0d r=%0d want %0d %0d %0d", c, sum_ed, med_q, med_r, e_sum, e_q, e_r);
      end
      checks++;
      if (d - k !== SUM_W + 1 || da !== 1'b0) begin
        errors++; $display("FAIL rand%0d_timing: got lat=%0d done_next=%b want %0d 0", c, d - k, da, SUM_W + 1);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_zero_samples();
    test_gaps();
    test_reset_rerun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
